// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the fifo_sync read path.
// Used by fifo_rd_ring and fifo_rd_stream_adapter.
package fifo_pkg;

    localparam int DEF_WIDTH         = 8;
    localparam int RD_PREFETCH_DEPTH = 3;

    function automatic int clogb2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    localparam int RD_PTR_W = clogb2(RD_PREFETCH_DEPTH);
    localparam int RD_OCC_W = clogb2(RD_PREFETCH_DEPTH + 1);

endpackage

// File: rtl/fifo_rd_ring.sv
// fifo_rd_ring: 3-entry prefetch ring with mod-3 pointers and fill count.
// Storage and pointers clear on the asynchronous active-low rst.
module fifo_rd_ring
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [WIDTH-1:0]    wdata,
    output logic [WIDTH-1:0]    rdata,
    output logic [RD_OCC_W-1:0] occ
);

    logic [WIDTH-1:0]    mem [RD_PREFETCH_DEPTH];
    logic [RD_PTR_W-1:0] wr_ptr;
    logic [RD_PTR_W-1:0] rd_ptr;
    logic                do_pop;

    // Depth is not a power of two, so wrap explicitly.
    function automatic logic [RD_PTR_W-1:0] inc(input logic [RD_PTR_W-1:0] p);
        return (p == RD_PTR_W'(RD_PREFETCH_DEPTH - 1)) ? '0 : p + RD_PTR_W'(1);
    endfunction

    assign do_pop = pop & (occ != '0);
    assign rdata  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < RD_PREFETCH_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= inc(rd_ptr);
            unique case ({push, do_pop})
                2'b10:   occ <= occ + RD_OCC_W'(1);
                2'b01:   occ <= occ - RD_OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    ring_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !do_pop && occ == RD_OCC_W'(RD_PREFETCH_DEPTH)));

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: fifo_sync read side to bubble-free valid/ready stream.
// Define FIFO_RD_STATS_EN to add the drained_cnt transfer counter port.
module fifo_rd_stream_adapter
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]      drained_cnt
`endif
);

    logic                run_q;
    logic                inflight_q;
    logic                xfer;
    logic [RD_OCC_W-1:0] occ;
    logic [RD_OCC_W:0]   budget;

    // Ring slots already claimed: filled entries plus the word on its way.
    assign budget     = {1'b0, occ} + {{RD_OCC_W{1'b0}}, inflight_q};
    assign fifo_rd_en = run_q & ~fifo_empty
                      & (budget < (RD_OCC_W + 1)'(RD_PREFETCH_DEPTH));
    assign m_valid    = (occ != '0);
    assign xfer       = m_valid & m_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q      <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            inflight_q <= fifo_rd_en;
        end
    end

    fifo_rd_ring #(
        .WIDTH (WIDTH)
    ) u_ring (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .pop   (xfer),
        .wdata (fifo_data),
        .rdata (m_data),
        .occ   (occ)
    );

`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drained_cnt <= '0;
        end else if (xfer) begin
            drained_cnt <= drained_cnt + 32'd1;
        end
    end
`endif

endmodule
